// File: rtl/shape_raster.sv
// shape_raster: streams rectangle, Bresenham line and midpoint circle pixels.
// Optional macro SHAPE_RASTER_FILL_EN adds filled rectangles (shape=1, fill=1).
module shape_raster #(
   parameter int COORD_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [1:0]         shape,
   input  logic               fill,
   input  logic [COORD_W-1:0] x0,
   input  logic [COORD_W-1:0] y0,
   input  logic [COORD_W-1:0] x1,
   input  logic [COORD_W-1:0] y1,
   input  logic [COORD_W-1:0] radius,
   input  logic               abort,
   output logic [COORD_W-1:0] px_x,
   output logic [COORD_W-1:0] px_y,
   output logic               px_valid,
   input  logic               px_ready,
   output logic               busy,
   output logic               done,
   output logic               aborted
);
   localparam int EW = COORD_W + 2;
   typedef logic [COORD_W-1:0] crd_t;
   typedef logic [EW-1:0]      err_t;
   typedef enum logic [2:0] {
      IDLE, SETUP, RECT, LINE, CIRC, FINISH
   } state_t;

   localparam crd_t ONE  = crd_t'(1);
   localparam crd_t MONE = '1;

`ifdef SHAPE_RASTER_FILL_EN
   localparam logic FILL_EN = 1'b1;
`else
   localparam logic FILL_EN = 1'b0;
`endif

   state_t     state_q;
   logic [1:0] shape_q;
   logic       fill_q;
   crd_t       ax_q, ay_q, bx_q, by_q, rad_q;
   crd_t       ox_q, oy_q;
   logic [2:0] ph_q;
   err_t       err_q, dx_q, dy_q;
   logic       sxn_q, syn_q;
   crd_t       px_x_q, px_y_q;
   logic       px_valid_q, busy_q, done_q, aborted_q;

   crd_t       nx_d, ny_d, ox_d, oy_d, ox1, oy1;
   logic [2:0] ph_d;
   err_t       err_d;
   logic       last_d;

   crd_t mnx, mxx, mny, mxy, adx, ady;
   logic signed [EW:0] e2;
   logic step_x, step_y;

   assign mnx = (ax_q < bx_q) ? ax_q : bx_q;
   assign mxx = (ax_q < bx_q) ? bx_q : ax_q;
   assign mny = (ay_q < by_q) ? ay_q : by_q;
   assign mxy = (ay_q < by_q) ? by_q : ay_q;
   assign adx = mxx - mnx;
   assign ady = mxy - mny;

   // Both Bresenham tests use the pre-update error term.
   assign e2     = $signed({err_q, 1'b0});
   assign step_x = e2 > -$signed({1'b0, dy_q});
   assign step_y = e2 < $signed({1'b0, dx_q});

   function automatic logic [2*COORD_W-1:0] circ_pt(
      input logic [2:0] k,
      input crd_t cx,
      input crd_t cy,
      input crd_t x,
      input crd_t y
   );
      crd_t px, py;
      px = cx;
      py = cy;
      case (k)
         3'd0: begin px = cx + x; py = cy + y; end
         3'd1: begin px = cx + y; py = cy + x; end
         3'd2: begin px = cx - y; py = cy + x; end
         3'd3: begin px = cx - x; py = cy + y; end
         3'd4: begin px = cx - x; py = cy - y; end
         3'd5: begin px = cx - y; py = cy - x; end
         3'd6: begin px = cx + y; py = cy - x; end
         default: begin px = cx + x; py = cy - y; end
      endcase
      return {px, py};
   endfunction

   always_comb begin
      nx_d   = px_x_q;
      ny_d   = px_y_q;
      ph_d   = ph_q;
      err_d  = err_q;
      ox_d   = ox_q;
      oy_d   = oy_q;
      last_d = 1'b0;
      ox1    = ox_q;
      oy1    = oy_q + ONE;
      unique case (state_q)
         RECT: begin
            case (ph_q)
               3'd0: if (px_x_q == mxx) begin
                  if (px_y_q == mxy) last_d = 1'b1;
                  else begin
                     ny_d = mny + ONE;
                     ph_d = 3'd1;
                  end
               end else nx_d = px_x_q + ONE;
               3'd1: if (px_y_q == mxy) begin
                  if (px_x_q == mnx) last_d = 1'b1;
                  else begin
                     nx_d = mxx - ONE;
                     ph_d = 3'd2;
                  end
               end else ny_d = px_y_q + ONE;
               3'd2: if (px_x_q == mnx) begin
                  if (mxy - ONE == mny) last_d = 1'b1;
                  else begin
                     ny_d = mxy - ONE;
                     ph_d = 3'd3;
                  end
               end else nx_d = px_x_q - ONE;
               3'd3: if (px_y_q == mny + ONE) last_d = 1'b1;
               else ny_d = px_y_q - ONE;
               default: if (px_x_q == mxx) begin
                  if (px_y_q == mxy) last_d = 1'b1;
                  else begin
                     nx_d = mnx;
                     ny_d = px_y_q + ONE;
                  end
               end else nx_d = px_x_q + ONE;
            endcase
         end
         LINE: begin
            if (px_x_q == bx_q && px_y_q == by_q) last_d = 1'b1;
            else begin
               if (step_x) begin
                  err_d = err_d - dy_q;
                  nx_d  = px_x_q + (sxn_q ? MONE : ONE);
               end
               if (step_y) begin
                  err_d = err_d + dx_q;
                  ny_d  = px_y_q + (syn_q ? MONE : ONE);
               end
            end
         end
         CIRC: begin
            if (ox_q == '0 && oy_q == '0) last_d = 1'b1;
            else if (ph_q != 3'd7) begin
               ph_d = ph_q + 3'd1;
               {nx_d, ny_d} = circ_pt(ph_d, ax_q, ay_q, ox_q, oy_q);
            end else begin
               if (err_q[EW-1]) begin
                  err_d = err_q + {1'b0, oy1, 1'b1};
               end else begin
                  ox1   = ox_q - ONE;
                  err_d = err_q + {1'b0, oy1, 1'b1} - {1'b0, ox1, 1'b0};
               end
               if (oy1 > ox1) last_d = 1'b1;
               else begin
                  ph_d = 3'd0;
                  ox_d = ox1;
                  oy_d = oy1;
                  {nx_d, ny_d} = circ_pt(3'd0, ax_q, ay_q, ox1, oy1);
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         px_x_q     <= '0;
         px_y_q     <= '0;
         px_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         aborted_q  <= 1'b0;
      end else begin
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
         if (busy_q && abort) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            px_valid_q <= 1'b0;
            aborted_q  <= 1'b1;
         end else begin
            unique case (state_q)
               IDLE: if (start && shape != 2'd0) begin
                  shape_q <= shape;
                  fill_q  <= fill & FILL_EN;
                  ax_q    <= x0;
                  ay_q    <= y0;
                  bx_q    <= x1;
                  by_q    <= y1;
                  rad_q   <= radius;
                  busy_q  <= 1'b1;
                  state_q <= SETUP;
               end
               SETUP: begin
                  px_valid_q <= 1'b1;
                  ph_q       <= 3'd0;
                  unique case (shape_q)
                     2'd1: begin
                        px_x_q  <= mnx;
                        px_y_q  <= mny;
                        ph_q    <= fill_q ? 3'd4 : 3'd0;
                        state_q <= RECT;
                     end
                     2'd3: begin
                        px_x_q  <= ax_q;
                        px_y_q  <= ay_q;
                        dx_q    <= {2'b00, adx};
                        dy_q    <= {2'b00, ady};
                        err_q   <= {2'b00, adx} - {2'b00, ady};
                        sxn_q   <= bx_q < ax_q;
                        syn_q   <= by_q < ay_q;
                        state_q <= LINE;
                     end
                     default: begin
                        ox_q    <= rad_q;
                        oy_q    <= '0;
                        err_q   <= err_t'(1) - {2'b00, rad_q};
                        px_x_q  <= ax_q + rad_q;
                        px_y_q  <= ay_q;
                        state_q <= CIRC;
                     end
                  endcase
               end
               RECT, LINE, CIRC: if (px_valid_q && px_ready) begin
                  if (last_d) begin
                     px_valid_q <= 1'b0;
                     busy_q     <= 1'b0;
                     done_q     <= 1'b1;
                     state_q    <= FINISH;
                  end else begin
                     px_x_q <= nx_d;
                     px_y_q <= ny_d;
                     ph_q   <= ph_d;
                     err_q  <= err_d;
                     ox_q   <= ox_d;
                     oy_q   <= oy_d;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign px_x     = px_x_q;
   assign px_y     = px_y_q;
   assign px_valid = px_valid_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign aborted  = aborted_q;
endmodule
